// File: rtl/stim_replay_pkg.sv
// Shared types and word-layout helpers for the stimulus replay sequencer.
// A stored word is {obs, data}, with data in the low bits.
package stim_replay_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'd0,
        MODE_LOOP    = 2'd1,
        MODE_STEP    = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DATA_OFS = 0;

    function automatic int obs_ofs(input int data_w);
        return data_w;
    endfunction

    function automatic int word_w(input int data_w, input int obs_w);
        return data_w + obs_w;
    endfunction

    // The reserved encoding falls back to one-shot replay.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_LOOP;
            2'd2:    return MODE_STEP;
            default: return MODE_ONESHOT;
        endcase
    endfunction

endpackage

// File: rtl/stim_replay_mem.sv
// Programme RAM: one write port, one registered read port.
// The read register doubles as the replay output and can be cleared.
module stim_replay_mem
    import stim_replay_pkg::*;
#(
    parameter int WORD_W = 129,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_clr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rd_data_q, rd_data_d;

    // Array contents survive reset so a loaded programme can be replayed again.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_clr) begin
            rd_data_d = '0;
        end else if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/stim_replay_seq.sv
// Stimulus replay sequencer: replays a RAM programme one word per advance
// in one-shot, loop or single-step mode with start/stop/done handshake.
module stim_replay_seq
    import stim_replay_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int OBS_W  = 1,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int WRAP_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [OBS_W+DATA_W-1:0] wr_data,
    input  logic                    start,
    input  logic                    stop,
    input  logic [1:0]              mode,
    input  logic                    step,
    input  logic [ADDR_W-1:0]       last_addr,
    output logic [DATA_W-1:0]       data_out,
    output logic [OBS_W-1:0]        obs_out,
    output logic                    valid,
    output logic [ADDR_W-1:0]       pc,
    output logic                    busy,
    output logic                    done,
    output logic [WRAP_W-1:0]       wrap_cnt
);

    localparam int                WORD_W   = OBS_W + DATA_W;
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic              first_q, first_d;
    logic              fin_q, fin_d;
    logic              valid_q, valid_d;

    logic              in_run;
    logic              start_ok;
    logic              adv;
    logic              at_last;
    logic              wr_ok;
    logic [WORD_W-1:0] rd_word;

    // fin_q marks that the final word has gone out; DONE follows one cycle later.
    always_comb begin
        in_run   = (state_q == ST_RUN);
        start_ok = !in_run && start && !stop;
        adv      = in_run && !stop && !fin_q && (mode_q != MODE_STEP || step);
        at_last  = (pc_q == last_q);
        wr_ok    = wr_en && !in_run;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
                ST_RUN:           if (fin_q) state_d = ST_DONE;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state_q == ST_RUN);
        done     = (state_q == ST_DONE);
        valid    = valid_q;
        pc       = pc_q;
        wrap_cnt = wrap_q;
    end

    // The pass counter steps with the RAM[0] word of every pass after the first.
    always_comb begin
        pc_d    = pc_q;
        last_d  = last_q;
        mode_d  = mode_q;
        wrap_d  = wrap_q;
        first_d = first_q;
        fin_d   = fin_q;
        valid_d = 1'b0;
        if (stop) begin
            fin_d = 1'b0;
        end else if (start_ok) begin
            pc_d    = '0;
            wrap_d  = '0;
            mode_d  = decode_mode(mode);
            last_d  = (last_addr > MAX_ADDR) ? MAX_ADDR : last_addr;
            first_d = 1'b1;
            fin_d   = 1'b0;
        end else if (adv) begin
            valid_d = 1'b1;
            first_d = 1'b0;
            if (pc_q == '0 && !first_q && wrap_q != '1) begin
                wrap_d = wrap_q + 1'b1;
            end
            if (!at_last) begin
                pc_d = pc_q + 1'b1;
            end else if (mode_q == MODE_LOOP) begin
                pc_d = '0;
            end else begin
                fin_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            last_q  <= '0;
            mode_q  <= MODE_ONESHOT;
            wrap_q  <= '0;
            first_q <= 1'b0;
            fin_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            last_q  <= last_d;
            mode_q  <= mode_d;
            wrap_q  <= wrap_d;
            first_q <= first_d;
            fin_q   <= fin_d;
            valid_q <= valid_d;
        end
    end

    stim_replay_mem #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (adv),
        .rd_clr  (stop),
        .rd_addr (pc_q),
        .rd_data (rd_word)
    );

    assign data_out = rd_word[DATA_W-1:0];
    assign obs_out  = rd_word[WORD_W-1:DATA_W];

endmodule

// File: tb/tb_stim_replay_seq.sv
// Scoreboard bench for stim_replay_seq: stimulus queues expected words,
// a negedge monitor pops and compares every valid output word.
module tb_stim_replay_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en;
    logic [5:0]   wr_addr;
    logic [128:0] wr_data;
    logic         start;
    logic         stop;
    logic [1:0]   mode;
    logic         step;
    logic [5:0]   last_addr;
    logic [127:0] data_out;
    logic [0:0]   obs_out;
    logic         valid;
    logic [5:0]   pc;
    logic         busy;
    logic         done;
    logic [15:0]  wrap_cnt;

    typedef struct {
        logic [127:0] data;
        logic [0:0]   obs;
        logic [15:0]  wrap;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    stim_replay_seq dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .step      (step),
        .last_addr (last_addr),
        .data_out  (data_out),
        .obs_out   (obs_out),
        .valid     (valid),
        .pc        (pc),
        .busy      (busy),
        .done      (done),
        .wrap_cnt  (wrap_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [127:0] d, input logic [0:0] o, input logic [15:0] w);
        exp_t e;
        e.data = d;
        e.obs  = o;
        e.wrap = w;
        sb.push_back(e);
    endtask

    task automatic push_abcd(input logic [15:0] w);
        push_exp(128'hA, 1'b1, w);
        push_exp(128'hB, 1'b0, w);
        push_exp(128'hC, 1'b1, w);
        push_exp(128'hD, 1'b0, w);
    endtask

    task automatic write_word(input logic [5:0] a, input logic [0:0] o, input logic [127:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = {o, d};
        tick(1);
        wr_en   = 1'b0;
    endtask

    task automatic kick(input logic [1:0] m, input logic [5:0] l);
        mode      = m;
        last_addr = l;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
    endtask

    // Monitor: every valid word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got data %0h with no expected word", data_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("word_data", data_out, e.data);
                chk("word_obs", obs_out, e.obs);
                chk("word_wrap", wrap_cnt, e.wrap);
            end
        end
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; mode = 2'd0; step = 1'b0; last_addr = '0;
        tick(2);
        chk("rst_data", data_out, 0);
        chk("rst_obs", obs_out, 0);
        chk("rst_valid", valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap", wrap_cnt, 0);
        rst = 1'b0;
        tick(1);

        write_word(6'd0, 1'b1, 128'hA);
        write_word(6'd1, 1'b0, 128'hB);
        write_word(6'd2, 1'b1, 128'hC);
        write_word(6'd3, 1'b0, 128'hD);

        // One-shot over four words.
        push_abcd(16'd0);
        kick(2'd0, 6'd3);
        chk("os_busy", busy, 1);
        chk("os_pc0", pc, 0);
        chk("os_valid_lat", valid, 0);
        tick(4);
        chk("os_last_valid", valid, 1);
        chk("os_last_notdone", done, 0);
        tick(1);
        chk("os_done", done, 1);
        chk("os_done_valid", valid, 0);
        chk("os_done_hold", data_out, 128'hD);
        chk("os_done_busy", busy, 0);

        // Loop, restarted from DONE; stop together with start aborts.
        push_abcd(16'd0);
        push_abcd(16'd1);
        push_exp(128'hA, 1'b1, 16'd2);
        kick(2'd1, 6'd3);
        tick(9);
        chk("loop_third_a", data_out, 128'hA);
        chk("loop_wrap2", wrap_cnt, 2);
        stop = 1'b1; start = 1'b1;
        tick(1);
        stop = 1'b0; start = 1'b0;
        chk("stop_data", data_out, 0);
        chk("stop_obs", obs_out, 0);
        chk("stop_valid", valid, 0);
        chk("stop_busy", busy, 0);
        chk("stop_done", done, 0);
        chk("stop_wrap", wrap_cnt, 2);

        // Single-step: two pulses, output held in between.
        push_exp(128'hA, 1'b1, 16'd0);
        push_exp(128'hB, 1'b0, 16'd0);
        kick(2'd2, 6'd3);
        tick(2);
        step = 1'b1; tick(1); step = 1'b0;
        tick(3);
        chk("step_hold_a", data_out, 128'hA);
        chk("step_hold_valid", valid, 0);
        chk("step_busy", busy, 1);
        step = 1'b1; tick(1); step = 1'b0;
        tick(2);
        chk("step_hold_b", data_out, 128'hB);
        chk("step_pc", pc, 2);
        stop = 1'b1; tick(1); stop = 1'b0;

        // Write during RUN is dropped.
        push_abcd(16'd0);
        kick(2'd0, 6'd3);
        wr_en = 1'b1; wr_addr = 6'd0; wr_data = {1'b0, 128'hFF};
        tick(1);
        wr_en = 1'b0;
        tick(4);
        chk("wrrun_done1", done, 1);
        push_abcd(16'd0);
        kick(2'd0, 6'd3);
        tick(5);
        chk("wrrun_done2", done, 1);

        // Write in the start cycle from IDLE is seen by the first read.
        stop = 1'b1; tick(1); stop = 1'b0;
        push_exp(128'hFF, 1'b1, 16'd0);
        wr_en = 1'b1; wr_addr = 6'd0; wr_data = {1'b1, 128'hFF};
        kick(2'd0, 6'd0);
        wr_en = 1'b0;
        tick(2);
        chk("wrstart_done", done, 1);
        chk("wrstart_data", data_out, 128'hFF);
        write_word(6'd0, 1'b1, 128'hA);

        // Single-word loop repeats every cycle.
        push_exp(128'hA, 1'b1, 16'd0);
        push_exp(128'hA, 1'b1, 16'd1);
        push_exp(128'hA, 1'b1, 16'd2);
        kick(2'd1, 6'd0);
        tick(3);
        stop = 1'b1; tick(1); stop = 1'b0;
        chk("loop1_wrap", wrap_cnt, 2);

        // Reset mid-run, then the programme still replays.
        push_exp(128'hA, 1'b1, 16'd0);
        push_exp(128'hB, 1'b0, 16'd0);
        kick(2'd0, 6'd3);
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("mrst_data", data_out, 0);
        chk("mrst_obs", obs_out, 0);
        chk("mrst_valid", valid, 0);
        chk("mrst_pc", pc, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_wrap", wrap_cnt, 0);
        rst = 1'b0;
        tick(1);
        push_abcd(16'd0);
        kick(2'd0, 6'd3);
        tick(5);
        chk("post_rst_done", done, 1);
        chk("post_rst_data", data_out, 128'hD);

        tick(2);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stim_replay_seq.md
# stim_replay_seq

Synthesizable, parametrised stimulus replay sequencer for concolic/coverage test harnesses. It stores a programme of stimulus words in an internal RAM and replays one word per clock onto a DUT data bus plus observation-strobe bits. It adds one-shot, loop and single-step modes, a start/stop/done handshake and runtime programme length. It sits between the harness loader (which fills the RAM) and the DUT top's stimulus inputs (e.g. `key`, `__obs`).

## Interface
Parameters:
- `DATA_W`, 128, width of the DUT stimulus bus.
- `OBS_W`, 1, number of observation-strobe bits per word.
- `DEPTH`, 64, programme RAM depth in words (≥2).
- `ADDR_W`, `$clog2(DEPTH)`, address/pc width (derived).
- `WRAP_W`, 16, width of the loop-pass counter.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: RAM write strobe.
- `wr_addr` in ADDR_W: RAM write address.
- `wr_data` in OBS_W+DATA_W: word; `[OBS_W+DATA_W-1:DATA_W]` = obs, `[DATA_W-1:0]` = data.
- `start` in 1: begin replay (accepted in IDLE or DONE only).
- `stop` in 1: abort to IDLE.
- `mode` in 2: 0 ONESHOT, 1 LOOP, 2 STEP, 3 reserved (treated as ONESHOT); sampled at start.
- `step` in 1: advance one word in STEP mode.
- `last_addr` in ADDR_W: index of final programme word; sampled at start.
- `data_out` out DATA_W: replayed data.
- `obs_out` out OBS_W: replayed observation bits.
- `valid` out 1: `data_out`/`obs_out` updated this cycle.
- `pc` out ADDR_W: address of the word to be emitted next.
- `busy` out 1: state is RUN.
- `done` out 1: state is DONE.
- `wrap_cnt` out WRAP_W: completed loop passes, saturating.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start`=1 → RUN. Next cycle: pc=0, wrap_cnt=0; latched mode and last_addr = min(`last_addr`, DEPTH-1).
- RUN, advance condition is every cycle in ONESHOT/LOOP and `step`=1 in STEP.
- On advance: `data_out`/`obs_out` ← RAM[pc], `valid`=1.
  - If pc≠last: pc+1.
  - If pc=last and LOOP: pc←0, wrap_cnt+1 (saturates at all-ones).
  - If pc=last and ONESHOT/STEP: → DONE.
- Not advancing (STEP, `step`=0): outputs hold, `valid`=0.
- DONE: `done`=1, outputs hold the last word, `valid`=0. `start` → RUN (restart, same semantics as from IDLE).
- `stop`=1 in any state → IDLE next cycle. `data_out`/`obs_out`/`valid` clear to 0; `stop` has priority over `start`, `step` and the wrap.
- Writes are accepted only when not busy. `wr_en` in RUN is ignored (no RAM change). A write in the same cycle as an accepted `start` takes effect and is visible to the first read.
- `start` while in RUN is ignored.
- RAM contents are not affected by `rst`.

## Timing
- Reset values: state IDLE, `data_out`=0, `obs_out`=0, `valid`=0, `pc`=0, `busy`=0, `done`=0, `wrap_cnt`=0.
- Start latency: `start` at edge N → `busy` from N+1, first `valid` word (RAM[0]) at edge N+2.
- ONESHOT with last_addr=L: L+1 consecutive `valid` cycles, then `done` asserts the cycle after the final word.
- LOOP: no bubble at wrap; RAM[L] then RAM[0] are on consecutive cycles, and wrap_cnt increments with the RAM[0] word.
- `last_addr`=0: single word, repeated every cycle in LOOP.
- Synchronous RAM read: pc registered; output registered from a read issued the previous cycle.

## Structure
- Package `stim_replay_pkg`: `mode_e` (ONESHOT, LOOP, STEP) and `state_e` (IDLE, RUN, DONE) typedefs; word-layout offset constants.
- Sub-module `stim_replay_mem`: simple dual-port RAM with one write port and one synchronous read port, DEPTH × (OBS_W+DATA_W).
- The control FSM, pc and wrap counter live in the top.

## Test plan
- Load RAM[0..3] = {1,0xA}, {0,0xB}, {1,0xC}, {0,0xD}; ONESHOT, last_addr=3 → 4 valid cycles with data A,B,C,D and obs 1,0,1,0; `done`=1 on the next cycle with data held at D.
- Same programme in LOOP → sequence A,B,C,D,A,B… with no gap; wrap_cnt=1 on the second A and 2 on the third A.
- STEP with `step` pulsed at cycles 3 and 7 → `valid` only on those advances, data A then B, held between.
- `stop` asserted mid-LOOP together with `start` → IDLE next cycle; data/obs/valid=0 and wrap_cnt unchanged.
- `wr_en` to address 0 with 0xFF during RUN → ignored; the next pass still shows A. The same write in the cycle of `start` from IDLE → the first word is 0xFF.
- `rst` asserted mid-RUN → all outputs at reset values next cycle; RAM contents still replay correctly after a new `start`.
